mem_access_ctrl: RTL and testbench

Sequencer between the memory stage and the single-port data memory. It accepts one load or store per transaction and issues one aligned word access, or two when the access crosses a word boundary. It merges the returned words, then sign- or zero-extends load data, or generates byte enables and shifted write data for stores. It holds the pipeline stalled until the transaction completes.

---
 rtl/mem_access_ctrl_pkg.sv | 52 +++++
 rtl/mem_access_ctrl_if.sv | 40 ++++
 rtl/mem_access_ctrl_load_align_ext.sv | 25 ++
 rtl/mem_access_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: RV32I width codes,
// sequencer state encoding and access classification helpers.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } mac_state_t;

  // Halfwords split only at offset 3; words split at any nonzero offset.
  function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] off);
    logic split;
    case (funct3[1:0])
      2'b01:   split = (off == 2'd3);
      2'b10:   split = (off != 2'd0);
      default: split = 1'b0;
    endcase
    return split;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    if (we) bad = funct3[2] || (funct3 == 3'b011);
    else    bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    return bad;
  endfunction

  // Byte-lane mask for an access of the given width, before offset shifting.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, memory and response signals of the access sequencer.
// master = sequencer view, slave = memory stage plus data memory view.
interface mem_access_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_err, stall
  );

endinterface

// File: rtl/mem_access_ctrl_load_align_ext.sv
// Merges up to two returned words, shifts the addressed bytes down to bit 0
// and sign- or zero-extends according to the load width.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Byte-offset shift of the merged pair, then width select and extension.
  always_comb begin
    shifted = 32'({hi, lo} >> {off, 3'b000});
    case (funct3[1:0])
      2'b00:   data = funct3[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   data = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the memory stage and a single-port data
// memory. Issues one or two aligned word accesses per transaction, merges
// and extends load data, and stalls the pipeline until the response pulse.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.master bus
);

  mac_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        split_q, split_d;
  logic [3:0]  hi_be_q, hi_be_d;
  logic [31:0] hi_wdata_q, hi_wdata_d;
  logic [31:0] word0_q, word0_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [7:0]  be64;
  logic [63:0] wd64;
  logic [31:0] align_lo, align_hi, load_data;

  // Lane alignment of the incoming request: both words' enables and data.
  always_comb begin
    be64 = {4'b0000, size_mask(bus.req_funct3)} << bus.req_addr[1:0];
    wd64 = {32'b0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
  end

  // Word 0 comes from the buffer only when the second word is returning.
  always_comb begin
    align_lo = bus.mem_rdata;
    align_hi = '0;
    if (state_q == ST_WAIT1) begin
      align_lo = word0_q;
      align_hi = bus.mem_rdata;
    end
  end

  load_align_ext u_align (
    .lo     (align_lo),
    .hi     (align_hi),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Sequencer next state, memory request registers and response formation.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    split_d     = split_q;
    hi_be_d     = hi_be_q;
    hi_wdata_d  = hi_wdata_q;
    word0_d     = word0_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          funct3_d   = bus.req_funct3;
          off_d      = bus.req_addr[1:0];
          split_d    = is_split(bus.req_funct3, bus.req_addr[1:0]);
          hi_be_d    = be64[7:4];
          hi_wdata_d = wd64[63:32];
          if (is_illegal(bus.req_we, bus.req_funct3)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_be_d    = be64[3:0];
            mem_wdata_d = wd64[31:0];
          end
        end
      end

      ST_REQ0, ST_REQ1: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!we_q) begin
            state_d = (state_q == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
          end else if ((state_q == ST_REQ0) && split_q) begin
            state_d     = ST_REQ1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_be_d    = hi_be_q;
            mem_wdata_d = hi_wdata_q;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end

      ST_WAIT0: begin
        if (bus.mem_rvalid) begin
          word0_d = bus.mem_rdata;
          if (split_q) begin
            state_d     = ST_REQ1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_be_d    = hi_be_q;
            mem_wdata_d = hi_wdata_q;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
          end
        end
      end

      ST_WAIT1: begin
        if (bus.mem_rvalid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      split_q     <= 1'b0;
      hi_be_q     <= '0;
      hi_wdata_q  <= '0;
      word0_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      split_q     <= split_d;
      hi_be_q     <= hi_be_d;
      hi_wdata_q  <= hi_wdata_d;
      word0_q     <= word0_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.stall     = (state_q != ST_IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and random transactions
// against a byte-level reference memory with configurable grant/rvalid waits.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_access_ctrl_if bif();

  mem_access_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] ba);
    logic [31:0] w;
    w = rd_word({ba[31:2], 2'b00});
    return 8'(w >> {ba[1:0], 3'b000});
  endfunction

  task automatic idle_inputs();
    bif.req_valid  = 1'b0;
    bif.req_we     = 1'b0;
    bif.req_funct3 = '0;
    bif.req_addr   = '0;
    bif.req_wdata  = '0;
    bif.mem_gnt    = 1'b0;
    bif.mem_rvalid = 1'b0;
    bif.mem_rdata  = '0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_mem_req"},   32'(bif.mem_req),   32'd0);
    check({pfx, "_mem_we"},    32'(bif.mem_we),    32'd0);
    check({pfx, "_mem_addr"},  bif.mem_addr,       32'd0);
    check({pfx, "_mem_be"},    32'(bif.mem_be),    32'd0);
    check({pfx, "_mem_wdata"}, bif.mem_wdata,      32'd0);
    check({pfx, "_rsp_valid"}, 32'(bif.rsp_valid), 32'd0);
    check({pfx, "_rsp_err"},   32'(bif.rsp_err),   32'd0);
    check({pfx, "_rsp_rdata"}, bif.rsp_rdata,      32'd0);
    check({pfx, "_ready"},     32'(bif.req_ready), 32'd1);
    check({pfx, "_stall"},     32'(bif.stall),     32'd0);
  endtask

  // One transaction: model expectation, drive request, act as memory, check.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned g, input int unsigned r);
    logic        illegal;
    int unsigned size, n_acc, exp_lat, acc, gwait, rv_cnt, cyc;
    logic [31:0] ea [2];
    logic [3:0]  eb [2];
    logic [31:0] ew [2];
    logic [63:0] wd64;
    logic [31:0] exp_rd, v, ba, wa, rd_addr, m;
    logic        waiting, saw, done;

    illegal = we ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    n_acc   = 0;
    exp_rd  = '0;
    ea[0] = '0; ea[1] = '0; eb[0] = '0; eb[1] = '0;
    if (!illegal) begin
      for (int i = 0; i < int'(size); i++) begin
        ba = addr + 32'(i);
        wa = {ba[31:2], 2'b00};
        if (n_acc == 0 || wa != ea[n_acc-1]) begin
          ea[n_acc] = wa;
          eb[n_acc] = '0;
          n_acc++;
        end
        eb[n_acc-1][ba[1:0]] = 1'b1;
      end
      if (!we) begin
        v = '0;
        for (int i = 0; i < int'(size); i++) v = v | ({24'b0, rd_byte(addr + 32'(i))} << (8 * i));
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        exp_rd = v;
      end
    end
    wd64  = {32'b0, wdata} << (8 * addr[1:0]);
    ew[0] = wd64[31:0];
    ew[1] = wd64[63:32];
    exp_lat = 1;
    for (int j = 0; j < int'(n_acc); j++) exp_lat += g + 1 + (we ? 0 : r + 1);

    check("ready_before", 32'(bif.req_ready), 32'd1);
    bif.req_valid  = 1'b1;
    bif.req_we     = we;
    bif.req_funct3 = f3;
    bif.req_addr   = addr;
    bif.req_wdata  = wdata;
    @(posedge clk); #1;
    bif.req_valid  = 1'b0;
    bif.req_we     = 1'($urandom);
    bif.req_funct3 = 3'($urandom);
    bif.req_addr   = $urandom;
    bif.req_wdata  = $urandom;

    acc = 0; gwait = 0; rv_cnt = 0; rd_addr = '0;
    waiting = 1'b0; saw = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 60) begin
      cyc++;
      bif.mem_gnt    = 1'b0;
      bif.mem_rvalid = 1'b0;
      bif.mem_rdata  = $urandom;
      check("stall", 32'(bif.stall), 32'(!bif.req_ready));
      if (saw) begin
        check("rsp_pulse", 32'(bif.rsp_valid), 32'd0);
        check("ready_after", 32'(bif.req_ready), 32'd1);
        done = 1'b1;
      end else if (bif.rsp_valid) begin
        saw = 1'b1;
        check("latency", cyc, exp_lat);
        check("rsp_err", 32'(bif.rsp_err), 32'(illegal));
        check("rsp_rdata", bif.rsp_rdata, exp_rd);
        check("access_count", acc, n_acc);
        check("ready_in_resp", 32'(bif.req_ready), 32'd0);
      end else begin
        check("ready_busy", 32'(bif.req_ready), 32'd0);
      end
      if (!done && bif.mem_req) begin
        if (acc >= n_acc) begin
          check("extra_req", 32'(bif.mem_req), 32'd0);
        end else begin
          check("mem_addr", bif.mem_addr, ea[acc]);
          check("mem_be", 32'(bif.mem_be), 32'(eb[acc]));
          check("mem_we", 32'(bif.mem_we), 32'(we));
          if (we) check("mem_wdata", bif.mem_wdata, ew[acc]);
          if (gwait < g) begin
            gwait++;
            bif.mem_rvalid = 1'($urandom);
          end else begin
            bif.mem_gnt = 1'b1;
            gwait = 0;
            if (we) begin
              m = rd_word(ea[acc]);
              for (int l = 0; l < 4; l++) if (eb[acc][l]) m[8*l +: 8] = ew[acc][8*l +: 8];
              mem[ea[acc]] = m;
            end else begin
              waiting = 1'b1;
              rv_cnt  = r;
              rd_addr = ea[acc];
            end
            acc++;
          end
        end
      end else if (!done && waiting) begin
        if (rv_cnt > 0) begin
          rv_cnt--;
        end else begin
          bif.mem_rvalid = 1'b1;
          bif.mem_rdata  = rd_word(rd_addr);
          waiting = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    check("txn_done", 32'(done), 32'd1);
    idle_inputs();
  endtask

  // Reset asserted inside REQ0 (in_wait=0) or WAIT0 (in_wait=1).
  task automatic reset_abort(input logic in_wait);
    bif.req_valid  = 1'b1;
    bif.req_we     = 1'b0;
    bif.req_funct3 = F3_LW;
    bif.req_addr   = 32'h0000_0300;
    @(posedge clk); #1;
    bif.req_valid  = 1'b0;
    check("abort_req_up", 32'(bif.mem_req), 32'd1);
    if (in_wait) begin
      bif.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bif.mem_gnt = 1'b0;
    end
    check("abort_stall", 32'(bif.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", 32'(bif.mem_req), 32'd0);
    check("abort_ready", 32'(bif.req_ready), 32'd1);
    check("abort_stall_rst", 32'(bif.stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bif.mem_rvalid = 1'b1;
      bif.mem_rdata  = $urandom;
      @(posedge clk); #1;
      check("abort_no_rsp", 32'(bif.rsp_valid), 32'd0);
      check("abort_no_req", 32'(bif.mem_req), 32'd0);
    end
    idle_inputs();
    @(posedge clk); #1;
    check("abort_ready_after", 32'(bif.req_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_rst");

    mem[32'h0000_0100] = 32'hDEAD_BEEF;
    run_txn(1'b0, F3_LW, 32'h0000_0100, '0, 0, 0);
    mem[32'h0000_0100] = 32'h80FF_FFFF;
    run_txn(1'b0, F3_LB,  32'h0000_0103, '0, 0, 0);
    run_txn(1'b0, F3_LBU, 32'h0000_0103, '0, 0, 0);
    mem[32'h0000_0200] = 32'h4433_2211;
    mem[32'h0000_0204] = 32'h8877_6655;
    run_txn(1'b0, F3_LW, 32'h0000_0202, '0, 0, 0);
    run_txn(1'b1, F3_SH, 32'h0FFF_FFFF, 32'h0000_ABCD, 0, 0);
    run_txn(1'b0, F3_LHU, 32'h0FFF_FFFF, '0, 1, 1);
    run_txn(1'b0, F3_LW, 32'hFFFF_FFFE, '0, 0, 0);
    run_txn(1'b1, F3_SW, 32'hFFFF_FFFD, 32'h1234_5678, 0, 0);
    run_txn(1'b0, F3_LW, 32'h0000_0100, '0, 3, 2);
    run_txn(1'b0, 3'b011, 32'h0000_0040, '0, 0, 0);
    run_txn(1'b1, 3'b100, 32'h0000_0040, 32'hFFFF_FFFF, 0, 0);
    reset_abort(1'b0);
    reset_abort(1'b1);

    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                       : {24'h000001, 8'($urandom)};
      run_txn(1'($urandom), f3, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
